mem_stage_dmem: RTL
===================

// Module: mem_stage_dmem
// PURPOSE
//  MEM pipeline stage and data-memory responder; consumes the EXU memory request (addr, store data,
//  read/write enables, byte masks) plus the WB write-back triple. Registers the request, services it
//  against an internal word-organised data RAM, aligns and extends load data, and forwards the
//  result to WB and to the IDU data-hazard logic. Stalls upstream for multi-cycle reads.
// PARAMETERS
//  DEPTH       1024  data RAM depth in 32-bit words (power of two); index = addr[log2(DEPTH)+1:2]
//  RD_LATENCY  0     extra cycles a load spends in MEM before data is valid (0..3)
//  INIT_FILE   ""    $readmemh image for RAM; empty = RAM contents undefined after power-up
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  memAddr_i    in   32  byte address from EXU ALU
//  memData_i    in   32  store data (rt) from EXU
//  readWr_i     in   1   load request
//  writeWr_i    in   1   store request
//  rmask_i      in   4   load size: 0001 byte, 0011 half, 1111 word
//  wmask_i      in   4   store size: same encoding
//  ld_unsigned_i in  1   1 = zero-extend (LBU/LHU), 0 = sign-extend
//  regcData_i   in   32  EXU result (non-load write-back data)
//  regcAddr_i   in   5   destination register
//  regcWr_i     in   1   register write enable
//  stall_o      out  1   hold EXU/IDU/IFU pipeline registers
//  misalign_o   out  1   one-cycle pulse: misaligned access dropped
//  regcData     out  32  write-back data to WB
//  regcAddr     out  5   write-back address
//  regcWr       out  1   write-back enable
//  mem_regWr / mem_data(32) / mem_regAddr(5)  out  forwarding copy for hazard logic
// BEHAVIOUR
//  - Reset: all stage registers, counter and every output 0; RAM contents untouched.
//  - Capture: on posedge, if !stall_o, stage registers load all *_i inputs; if stall_o they hold.
//  - Wait counter cnt: loaded with RD_LATENCY when a load is captured, else 0; decrements while !=0.
//    stall_o = (cnt != 0). Load occupies MEM for RD_LATENCY+1 cycles; upstream held RD_LATENCY cycles.
//  - Load result valid when cnt==0: word = RAM[index]; byte lane = addr[1:0], half lane = addr[1];
//    extended to 32 bits per ld_unsigned; regcData = loaded value, else regcData = captured regcData_i.
//  - Store: commits at the posedge ending the cycle the store is in the stage register; byte enables =
//    size mask shifted left by addr[1:0]; data lane-replicated (byte x4, half x2). Never stalls.
//  - Misalignment: half with addr[0]=1, word with addr[1:0]!=0 -> no RAM write, regcWr=0,
//    misalign_o=1 for that cycle, cnt not loaded.
//  - Simultaneous readWr & writeWr: store wins, load ignored (treated as store; regcWr as captured).
//  - Unknown mask encoding with request set: treated as word.
//  - Address beyond DEPTH*4 wraps via index truncation; no error.
//  - regcWr forced 0 while stall_o; mem_regWr/mem_data/mem_regAddr = regcWr/regcData/regcAddr.
//  - Load followed by load-dependent instr: forwarding sees mem_regWr only when data valid.
//  - rst mid-stall: cnt cleared, stall_o drops immediately, pending load discarded, no RAM write.
// STRUCTURE
//  - Shared constants in Helpers.v: MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111.
//  - Sub-module mem_load_align: combinational lane select + sign/zero extension (word, addr[1:0],
//    size, unsigned) -> 32-bit result. RAM array, stage registers, counter, store path in top.
// TESTING
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> regcData=0xDEADBEEF, regcWr=1, stall_o never high (RD_LATENCY=0).
//  - SW 0 @0x4, SB 0xAB @0x5 -> LW @0x4 returns 0x0000AB00; SH 0x1234 @0x6 -> LW @0x4 = 0x1234AB00.
//  - Word 0x00008080 @0x8: LB @0x8 -> 0xFFFFFF80; LBU -> 0x00000080; LH -> 0xFFFF8080; LHU -> 0x00008080.
//  - RD_LATENCY=2: LW captured -> stall_o high exactly 2 cycles, regcWr=0 meanwhile, then data + regcWr=1;
//    next instruction captured the cycle after stall_o falls, inputs held during stall not lost.
//  - LW @0x2 and SH @0x3 -> misalign_o pulses 1 cycle each, regcWr=0, RAM word @0x0 unchanged.
//  - RD_LATENCY=3: assert rst in 2nd stall cycle -> stall_o=0, all outputs 0 same cycle; RAM data
//    written before reset still read back after release.

Source files
------------

// File: rtl/mem_stage_dmem_pkg.sv
// Purpose: shared size-mask constants, access-size decode and alignment helpers for the MEM stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_dmem_pkg;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Any encoding other than byte or half is handled as a full word.
    function automatic size_e decode_size(input logic [3:0] mask);
        size_e sz;
        case (mask)
            MASK_B:  sz = SZ_B;
            MASK_H:  sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] m;
        case (size)
            SZ_B:    m = MASK_B;
            SZ_H:    m = MASK_H;
            default: m = MASK_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_align.sv
// Purpose: load-data lane select plus sign/zero extension of a 32-bit RAM word.
// Latency: combinational.
// Backpressure: none.
// Ports: word (RAM word), lane (addr[1:0]), size (access size), is_unsigned (zero-extend), result.
module mem_load_align
    import mem_stage_dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        result = word;
        case (size)
            SZ_B:    result = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    result = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_dmem.sv
// Purpose: MEM pipeline stage with internal word-organised data RAM; loads/stores, write-back forwarding.
// Latency: stores commit at the end of their MEM cycle; loads return after RD_LATENCY extra cycles.
// Backpressure: stall_o holds upstream for RD_LATENCY cycles per aligned load; stores never stall.
// Ports: clk/rst; EXU request (memAddr_i, memData_i, readWr_i, writeWr_i, rmask_i, wmask_i,
//        ld_unsigned_i) and write-back triple (regcData_i, regcAddr_i, regcWr_i); outputs stall_o,
//        misalign_o, WB triple (regcData, regcAddr, regcWr) and forwarding copy (mem_*).
module mem_stage_dmem
    import mem_stage_dmem_pkg::*;
#(
    parameter int    DEPTH      = 1024,
    parameter int    RD_LATENCY = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic        readWr_i,
    input  logic        writeWr_i,
    input  logic [3:0]  rmask_i,
    input  logic [3:0]  wmask_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWr_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] regcData,
    output logic [4:0]  regcAddr,
    output logic        regcWr,
    output logic        mem_regWr,
    output logic [31:0] mem_data,
    output logic [4:0]  mem_regAddr
);

    localparam int AW = $clog2(DEPTH);

    // RAM contents are not reset; without a preload image they are undefined after power-up.
    logic [31:0] ram [DEPTH];

    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_rd;
    logic        s_wr;
    logic [3:0]  s_rmask;
    logic [3:0]  s_wmask;
    logic        s_uns;
    logic [31:0] s_regc_data;
    logic [4:0]  s_regc_addr;
    logic        s_regc_wr;
    logic [1:0]  cnt;

    // Only an aligned load that is not overridden by a store earns wait cycles.
    logic in_is_load;
    assign in_is_load = readWr_i && !writeWr_i &&
                        !is_misaligned(decode_size(rmask_i), memAddr_i[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_addr      <= '0;
            s_wdata     <= '0;
            s_rd        <= 1'b0;
            s_wr        <= 1'b0;
            s_rmask     <= '0;
            s_wmask     <= '0;
            s_uns       <= 1'b0;
            s_regc_data <= '0;
            s_regc_addr <= '0;
            s_regc_wr   <= 1'b0;
            cnt         <= '0;
        end else if (!stall_o) begin
            s_addr      <= memAddr_i;
            s_wdata     <= memData_i;
            s_rd        <= readWr_i;
            s_wr        <= writeWr_i;
            s_rmask     <= rmask_i;
            s_wmask     <= wmask_i;
            s_uns       <= ld_unsigned_i;
            s_regc_data <= regcData_i;
            s_regc_addr <= regcAddr_i;
            s_regc_wr   <= regcWr_i;
            cnt         <= in_is_load ? 2'(RD_LATENCY) : 2'd0;
        end else begin
            cnt <= cnt - 2'd1;
        end
    end

    // Stage-side decode; a store in the stage takes priority over a load.
    size_e       s_rsz;
    size_e       s_wsz;
    logic        s_is_load;
    logic        s_mis;
    logic [AW-1:0] s_index;

    assign s_rsz     = decode_size(s_rmask);
    assign s_wsz     = decode_size(s_wmask);
    assign s_is_load = s_rd && !s_wr;
    assign s_index   = s_addr[AW+1:2];
    assign s_mis     = s_wr      ? is_misaligned(s_wsz, s_addr[1:0]) :
                       s_is_load ? is_misaligned(s_rsz, s_addr[1:0]) : 1'b0;

    assign stall_o    = (cnt != 2'd0);
    assign misalign_o = s_mis;

    // Load path: asynchronous RAM read, lane-aligned and extended by the sub-module.
    logic [31:0] rd_word;
    logic [31:0] ld_result;

    assign rd_word = ram[s_index];

    mem_load_align u_align (
        .word        (rd_word),
        .lane        (s_addr[1:0]),
        .size        (s_rsz),
        .is_unsigned (s_uns),
        .result      (ld_result)
    );

    assign regcData = s_is_load ? ld_result : s_regc_data;
    assign regcAddr = s_regc_addr;
    // Write-back is withheld while the load is still waiting and for dropped accesses.
    assign regcWr   = s_regc_wr && !stall_o && !s_mis;

    assign mem_regWr   = regcWr;
    assign mem_data    = regcData;
    assign mem_regAddr = regcAddr;

    // Store path: replicate data across lanes, enable only the addressed bytes.
    logic [31:0] st_data;
    logic [3:0]  st_be;

    always_comb begin
        st_data = s_wdata;
        case (s_wsz)
            SZ_B:    st_data = {4{s_wdata[7:0]}};
            SZ_H:    st_data = {2{s_wdata[15:0]}};
            default: st_data = s_wdata;
        endcase
    end

    assign st_be = size_bytes(s_wsz) << s_addr[1:0];

    always_ff @(posedge clk) begin
        if (s_wr && !s_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    ram[s_index][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule
